// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// controller states and the iteration count.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int MD_ITERS = 32;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage controller and muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             HiWrite;
  logic             LoWrite;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, In1, In2, HiWrite, LoWrite,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, In1, In2, HiWrite, LoWrite,
    output Busy, Done, Hi, Lo
  );

endinterface

// File: rtl/muldiv_abs_neg32.sv
// Conditional two's-complement negate; cin lets two instances chain into a
// 64-bit negate (low word cin=1, high word cin = low word was zero).
module abs_neg32 (
  input  logic [31:0] in_val,
  input  logic        neg,
  input  logic        cin,
  output logic [31:0] out_val
);

  logic [31:0] inv_sum_s;

  // Invert-and-add, selected only when negation is requested
  always_comb begin
    inv_sum_s = ~in_val + {31'b0, cin};
    if (neg) begin
      out_val = inv_sum_s;
    end else begin
      out_val = in_val;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine with HI/LO registers; fixed
// 34-cycle latency from Start to Done regardless of op or operands.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg_s, b_neg_s, b_zero_s;
  logic [WIDTH-1:0]   a_abs_s, b_abs_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s;
  logic               fix_hi_cin_s;
  logic [WIDTH-1:0]   fix_lo_s, fix_hi_s;

  assign a_neg_s  = is_signed_op(bus.Op) & bus.In1[WIDTH-1];
  assign b_neg_s  = is_signed_op(bus.Op) & bus.In2[WIDTH-1];
  assign b_zero_s = (bus.In2 == {WIDTH{1'b0}});

  abs_neg32 u_abs_a (.in_val(bus.In1), .neg(a_neg_s), .cin(1'b1), .out_val(a_abs_s));
  abs_neg32 u_abs_b (.in_val(bus.In2), .neg(b_neg_s), .cin(1'b1), .out_val(b_abs_s));

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right
  assign mul_sum_s  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + ({1'b0, opr_q} & {(WIDTH+1){work_q[0]}});
  assign mul_next_s = {mul_sum_s, work_q[WIDTH-1:1]};

  // Divide: trial-subtract from the left-shifted remainder; a set top bit means borrow
  assign div_trial_s = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, opr_q};
  assign div_next_s  = div_trial_s[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                          : {div_trial_s[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  // Product negation borrows from the low word; quotient/remainder negate independently
  assign fix_hi_cin_s = is_div_q | (work_q[WIDTH-1:0] == {WIDTH{1'b0}});

  abs_neg32 u_fix_lo (.in_val(work_q[WIDTH-1:0]),       .neg(neg_lo_q), .cin(1'b1),         .out_val(fix_lo_s));
  abs_neg32 u_fix_hi (.in_val(work_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .cin(fix_hi_cin_s), .out_val(fix_hi_s));

  // Controller next-state, datapath step and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opr_d    = opr_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d  = RUN;
          cnt_d    = {CNT_W{1'b0}};
          busy_d   = 1'b1;
          is_div_d = is_div_op(bus.Op);
          if (is_div_op(bus.Op)) begin
            work_d   = {{WIDTH{1'b0}}, a_abs_s};
            opr_d    = b_abs_s;
            // A zero divisor leaves the all-ones quotient un-negated
            neg_lo_d = (a_neg_s ^ b_neg_s) & ~b_zero_s;
            neg_hi_d = a_neg_s;
          end else begin
            work_d   = {{WIDTH{1'b0}}, b_abs_s};
            opr_d    = a_abs_s;
            neg_lo_d = a_neg_s ^ b_neg_s;
            neg_hi_d = a_neg_s ^ b_neg_s;
          end
        end else begin
          if (bus.HiWrite) begin
            hi_d = bus.In1;
          end else begin
            hi_d = hi_q;
          end
          if (bus.LoWrite) begin
            lo_d = bus.In1;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (is_div_q) begin
          work_d = div_next_s;
        end else begin
          work_d = mul_next_s;
        end
        if (cnt_q == CNT_W'(MD_ITERS - 1)) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        hi_d    = fix_hi_s;
        lo_d    = fix_lo_s;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      work_q   <= {(2*WIDTH){1'b0}};
      opr_q    <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opr_q    <= opr_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized ops
// against an arithmetic reference, MT writes and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width arithmetic with MIPS-style divide-by-zero result
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) begin
          p = {a, 32'hFFFFFFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else            p = {a % b, a / b};
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op (called 1ns after an edge, unit not busy) and check the whole window
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] rh, rl;
    int          bad;
    ref_op(op, a, b, rh, rl);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.In1   = a;
    bus.In2   = b;
    tick();
    bus.Start = 1'b0;
    check_eq({tag, "_busy_start"}, 32'(bus.Busy), 32'h1);
    check_eq({tag, "_done_start"}, 32'(bus.Done), 32'h0);
    check_eq({tag, "_hi_hold"}, bus.Hi, exp_hi);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      bus.Start   = 1'($urandom_range(0, 1));
      bus.HiWrite = 1'($urandom_range(0, 1));
      bus.LoWrite = 1'($urandom_range(0, 1));
      bus.Op      = 2'($urandom_range(0, 3));
      bus.In1     = 32'($urandom);
      bus.In2     = 32'($urandom);
      tick();
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.Hi !== exp_hi || bus.Lo !== exp_lo) bad++;
    end
    bus.Start   = 1'b0;
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    check_eq({tag, "_run_window"}, 32'(bad), 32'h0);
    tick();
    check_eq({tag, "_busy_fix"}, 32'(bus.Busy), 32'h0);
    check_eq({tag, "_done_fix"}, 32'(bus.Done), 32'h1);
    check_eq({tag, "_hi"}, bus.Hi, rh);
    check_eq({tag, "_lo"}, bus.Lo, rl);
    exp_hi = rh;
    exp_lo = rl;
  endtask

  initial begin
    int bad;
    bus.Start   = 1'b0;
    bus.Op      = 2'b00;
    bus.In1     = 32'h0;
    bus.In2     = 32'h0;
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", 32'(bus.Busy), 32'h0);
    check_eq("rst_done", 32'(bus.Done), 32'h0);
    check_eq("rst_hi", bus.Hi, 32'h0);
    check_eq("rst_lo", bus.Lo, 32'h0);
    reset = 1'b0;
    tick();

    run_op(OP_MULT,  32'hFFFFFFFF, 32'h00000002, "mult_neg");
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, "multu_big");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, "div_neg");
    run_op(OP_DIVU,  32'h00000007, 32'h00000000, "divu_zero");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000000, "div_zero_neg");
    run_op(OP_MULT,  32'h80000000, 32'h80000000, "mult_min");
    tick();
    check_eq("done_single", 32'(bus.Done), 32'h0);

    bus.In1     = 32'h12345678;
    bus.HiWrite = 1'b1;
    tick();
    bus.HiWrite = 1'b0;
    exp_hi = 32'h12345678;
    check_eq("mthi_hi", bus.Hi, exp_hi);
    check_eq("mthi_lo", bus.Lo, exp_lo);
    bus.In1     = 32'hCAFEF00D;
    bus.LoWrite = 1'b1;
    tick();
    bus.LoWrite = 1'b0;
    exp_lo = 32'hCAFEF00D;
    check_eq("mtlo_lo", bus.Lo, exp_lo);
    check_eq("mtlo_hi", bus.Hi, exp_hi);
    bus.In1     = 32'h0BADBEEF;
    bus.HiWrite = 1'b1;
    bus.LoWrite = 1'b1;
    tick();
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    exp_hi = 32'h0BADBEEF;
    exp_lo = 32'h0BADBEEF;
    check_eq("mtboth_hi", bus.Hi, exp_hi);
    check_eq("mtboth_lo", bus.Lo, exp_lo);

    // Start and MTHI together: the write is dropped (checked via _hi_hold)
    bus.HiWrite = 1'b1;
    bus.LoWrite = 1'b1;
    run_op(OP_MULTU, 32'h55555555, 32'h00000003, "start_wins");

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), "rand");
    end

    // Mid-operation re-Start/MTHI, then asynchronous reset
    tick();
    bus.Start = 1'b1;
    bus.Op    = OP_MULTU;
    bus.In1   = 32'h00010001;
    bus.In2   = 32'h00020002;
    tick();
    bus.Start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    bus.Start   = 1'b1;
    bus.HiWrite = 1'b1;
    bus.In1     = 32'hDEADBEEF;
    tick();
    bus.Start   = 1'b0;
    bus.HiWrite = 1'b0;
    check_eq("abort_hi_hold", bus.Hi, exp_hi);
    check_eq("abort_busy", 32'(bus.Busy), 32'h1);
    for (int i = 11; i <= 19; i++) tick();
    #3;
    reset = 1'b1;
    #1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    check_eq("abort_rst_busy", 32'(bus.Busy), 32'h0);
    check_eq("abort_rst_done", 32'(bus.Done), 32'h0);
    check_eq("abort_rst_hi", bus.Hi, exp_hi);
    check_eq("abort_rst_lo", bus.Lo, exp_lo);
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Hi !== exp_hi) bad++;
    end
    check_eq("abort_no_done", 32'(bad), 32'h0);
    run_op(OP_DIVU, 32'd100, 32'd7, "post_rst");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the multi-cycle CPU's execute stage. It takes the same A/B operand registers as the ALU and produces the HI/LO register pair. The writeback mux reads HI/LO for MFHI/MFLO alongside ALUOut. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the controller FSM in a wait state through `Busy`.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `Start` input 1: launch request, sampled on a rising edge.
- `Op` input 2: operation, sampled with `Start`. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `In1` input 32: multiplicand or dividend (register A).
- `In2` input 32: multiplier or divisor (register B).
- `HiWrite` input 1: MTHI, loads `In1` into Hi.
- `LoWrite` input 1: MTLO, loads `In1` into Lo.
- `Busy` output 1: an operation is in progress.
- `Done` output 1: one-cycle completion pulse.
- `Hi` output 32: HI register (product high word or remainder).
- `Lo` output 32: LO register (product low word or quotient).

## Operation
- States:
  - IDLE: `Start` moves to RUN.
  - RUN: runs a 32-iteration counter, then moves to FIX.
  - FIX: always moves to IDLE.
- `Start` in IDLE:
  - Latches `Op` and the operand magnitudes. Signed ops take the two's-complement absolute value of each operand.
  - Latches the result-sign flags.
  - Clears the iteration counter.
- RUN, multiply: one shift-add step per cycle on a 64-bit accumulator, LSB first.
- RUN, divide: one restoring step per cycle on a 64-bit remainder/quotient pair, MSB first.
- FIX:
  - Negates the product if the operand signs differ (signed multiply).
  - Negates the quotient if the operand signs differ (signed divide).
  - Negates the remainder if the dividend was negative.
  - Writes Hi/Lo and pulses `Done`.
- Signed divide truncates toward zero. The remainder takes the dividend's sign.
- Divide by zero, both DIV and DIVU:
  - Lo = 32'hFFFFFFFF, Hi = original `In1`. No exception.
  - Latency is unchanged.
- DIV 32'h80000000 / 32'hFFFFFFFF gives Lo = 32'h80000000, Hi = 0.
- `Start` while `Busy` is ignored; the in-flight operation continues.
- `HiWrite`/`LoWrite`:
  - Take effect on the next edge, in IDLE only.
  - Ignored while `Busy`.
  - Ignored when `Start` is asserted in the same cycle: `Start` wins and the write is dropped.
  - Both asserted together loads both registers.
- Hi/Lo keep their last value until FIX or an MT write updates them.

## Timing
- Reset: state IDLE, `Busy` = 0, `Done` = 0, `Hi` = 0, `Lo` = 0, counter = 0. Reset takes effect immediately, including mid-operation. The partial result is discarded.
- `Start` sampled at edge k:
  - `Busy` = 1 from after edge k through edge k+33.
  - Iteration edges are k+1 through k+32.
  - FIX is at edge k+33.
- After edge k+33: `Busy` = 0, `Done` = 1 for exactly that cycle, Hi/Lo hold the new result.
- A new `Start` is accepted in the `Done` cycle and samples at edge k+34.
- Fixed latency of 34 cycles from `Start` to results available, independent of `Op` and operand values.
- `Busy` and `Done` are never high together.

## Structure
- Shared package `muldiv_pkg`:
  - Op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - State enum IDLE/RUN/FIX.
  - Constant `MD_ITERS` = 32.
- Single module: FSM, counter, 64-bit working register, sign flags, Hi/Lo.
- One natural sub-module `abs_neg32`: conditional two's-complement negate. It is instantiated for operand magnitude on entry and for result fix-up in FIX.

## Test plan
- MULT In1=32'hFFFFFFFF, In2=32'h00000002 → at edge k+33: Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFE, `Done` pulse of one cycle.
- MULTU with the same operands → Hi=32'h00000001, Lo=32'hFFFFFFFE.
- DIV In1=32'hFFFFFFF9 (-7), In2=2 → Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
- DIVU In1=7, In2=0 → Lo=32'hFFFFFFFF, Hi=7.
- DIV 32'h80000000 / 32'hFFFFFFFF → Lo=32'h80000000, Hi=0.
- Start on edge k, re-pulse `Start` and `HiWrite` at k+10, assert `reset` at k+20:
  - Re-`Start` and `HiWrite` have no effect.
  - `reset` forces `Busy`=0, Hi=Lo=0 immediately, with no `Done`.
- In IDLE, `HiWrite` with In1=32'h12345678 → Hi=32'h12345678 after one edge. The same with `Start` high in that cycle leaves Hi unchanged.
